// File: rtl/match_sequencer.sv
// match_sequencer: match scheduler driving the ball controller, scores, countdowns and match clock
module match_sequencer #(
  parameter int TICKS_PER_SEC = 25000000,
  parameter int KICKOFF_SECS = 3,
  parameter int SERVE_SECS = 1,
  parameter int WIN_SCORE = 5,
  parameter int MATCH_SECS = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       blue_score_up,
  input  logic       red_score_up,
  output logic       game_initiated,
  output logic       game_over,
  output logic [3:0] blue_score,
  output logic [3:0] red_score,
  output logic [3:0] countdown,
  output logic [7:0] time_left,
  output logic [1:0] winner,
  output logic [1:0] phase
);
  localparam int pw = $clog2(TICKS_PER_SEC);
  localparam logic [pw-1:0] tick_max = pw'(TICKS_PER_SEC - 1);
  localparam logic [3:0] kick_s = 4'(KICKOFF_SECS);
  localparam logic [3:0] serve_s = 4'(SERVE_SECS);
  localparam logic [3:0] win_s = 4'(WIN_SCORE);
  localparam logic [7:0] match_s = 8'(MATCH_SECS);
  typedef enum logic [1:0] {st_idle, st_cd, st_play, st_over} state_t;
  state_t state, next_state;
  logic [pw-1:0] presc;
  logic start_q, blue_q, red_q;
  logic start_rise, blue_evt, red_evt, sec_tick, goal, win_hit;
  logic [3:0] nb, nr;
  assign start_rise = start_btn & ~start_q;
  assign blue_evt = blue_score_up ^ blue_q;
  assign red_evt = red_score_up ^ red_q;
  assign sec_tick = presc == tick_max;
  assign goal = blue_evt | red_evt;
  assign nb = (blue_evt && blue_score != 4'hf) ? blue_score + 4'd1 : blue_score;
  assign nr = (red_evt && red_score != 4'hf) ? red_score + 4'd1 : red_score;
  assign win_hit = nb >= win_s || nr >= win_s;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= st_idle;
    else state <= next_state;
  // next-state decision
  always_comb begin
    next_state = state;
    case (state)
      st_idle, st_over: if (start_rise) next_state = st_cd;
      st_cd: if (sec_tick && countdown == 4'd1) next_state = st_play;
      st_play: next_state = (win_hit || (sec_tick && time_left <= 8'd1)) ? st_over : goal ? st_cd : st_play;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    game_over = state == st_over;
    phase = state;
  end
  // edge history, prescaler, scores, countdown, match clock and winner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start_q <= 1'b0;
      blue_q <= blue_score_up;
      red_q <= red_score_up;
      presc <= '0;
      game_initiated <= 1'b0;
      blue_score <= 4'd0;
      red_score <= 4'd0;
      countdown <= 4'd0;
      time_left <= match_s;
      winner <= 2'b00;
    end else begin
      start_q <= start_btn;
      blue_q <= blue_score_up;
      red_q <= red_score_up;
      presc <= (next_state != state || sec_tick) ? '0 : presc + pw'(1);
      game_initiated <= state == st_cd && next_state == st_play;
      case (state)
        st_idle, st_over:
          if (start_rise) begin
            blue_score <= 4'd0;
            red_score <= 4'd0;
            winner <= 2'b00;
            time_left <= match_s;
            countdown <= kick_s;
          end
        st_cd: if (sec_tick && countdown != 4'd0) countdown <= countdown - 4'd1;
        st_play: begin
          blue_score <= nb;
          red_score <= nr;
          if (next_state == st_cd) countdown <= serve_s;
          if (sec_tick && (!goal || time_left <= 8'd1) && time_left != 8'd0) time_left <= time_left - 8'd1;
          if (next_state == st_over) winner <= nb > nr ? 2'b01 : nr > nb ? 2'b10 : 2'b11;
        end
      endcase
    end
endmodule
